// File: rtl/keypad_scan_module.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_module
// Description : 4x4 matrix keypad scanner with whole-frame debounce and a
//               one-cycle strobe for each confirmed key press.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_module #(
  parameter int SCAN_DIV       = 200,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [3:0] Row_In,
  output logic [3:0] Col_Out,
  output logic [3:0] Key_Code,
  output logic       Key_Valid,
  output logic       Key_Held
);

  localparam logic [15:0] c_DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  c_DB       = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESSED  = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  logic [3:0]  r_row_meta;
  logic [3:0]  r_row_sync;
  logic [15:0] r_div;
  logic [1:0]  r_col_idx;
  logic [1:0]  r_acc_cnt;
  logic [3:0]  r_acc_key;
  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [3:0]  r_cand;

  logic        w_tick;
  logic        w_frame_end;
  logic [3:0]  w_low;
  logic [2:0]  w_samp_cnt;
  logic [1:0]  w_samp_row;
  logic [2:0]  w_sum;
  logic [1:0]  w_fr_cnt;
  logic [3:0]  w_fr_key;
  logic        w_none;
  logic        w_single;
  state_t      w_state_nxt;
  logic [3:0]  w_cnt_nxt;
  logic [3:0]  w_cand_nxt;
  logic        w_confirm;
  logic        w_release;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_row_meta <= 4'hF;
      r_row_sync <= 4'hF;
    end else begin
      r_row_meta <= Row_In;
      r_row_sync <= r_row_meta;
    end
  end

  assign w_tick      = (r_div == c_DIV_LAST);
  assign w_frame_end = w_tick && (r_col_idx == 2'd3);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_div     <= '0;
      r_col_idx <= 2'd0;
      Col_Out   <= 4'b1110;
    end else begin
      r_div <= w_tick ? '0 : r_div + 16'd1;
      if (w_tick) begin
        r_col_idx <= r_col_idx + 2'd1;
        Col_Out   <= {Col_Out[2:0], Col_Out[3]};
      end
    end
  end

  // Per-column sample: how many rows are low and which one (valid when exactly one)
  assign w_low = ~r_row_sync;

  always_comb begin
    w_samp_cnt = 3'd0;
    w_samp_row = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (w_low[i]) begin
        w_samp_cnt = w_samp_cnt + 3'd1;
        w_samp_row = 2'(i);
      end
    end
  end

  assign w_sum    = {1'b0, r_acc_cnt} + w_samp_cnt;
  assign w_fr_cnt = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
  assign w_fr_key = (r_acc_cnt == 2'd0) ? {r_col_idx, w_samp_row} : r_acc_key;
  assign w_none   = (w_fr_cnt == 2'd0);
  assign w_single = (w_fr_cnt == 2'd1);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_acc_cnt <= 2'd0;
      r_acc_key <= 4'd0;
    end else if (w_tick) begin
      if (r_col_idx == 2'd3) begin
        r_acc_cnt <= 2'd0;
        r_acc_key <= 4'd0;
      end else begin
        r_acc_cnt <= w_fr_cnt;
        r_acc_key <= w_fr_key;
      end
    end
  end

  // Debounce FSM advances only on the frame-end tick, using the completed frame
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_confirm   = 1'b0;
    w_release   = 1'b0;
    if (w_frame_end) begin
      case (r_state)
        S_IDLE: begin
          if (w_single) begin
            w_cand_nxt = w_fr_key;
            if (c_DB == 4'd1) begin
              w_confirm   = 1'b1;
              w_state_nxt = S_PRESSED;
              w_cnt_nxt   = 4'd0;
            end else begin
              w_state_nxt = S_DEBOUNCE;
              w_cnt_nxt   = 4'd1;
            end
          end
        end
        S_DEBOUNCE: begin
          if (w_single && (w_fr_key == r_cand)) begin
            if (r_cnt + 4'd1 >= c_DB) begin
              w_confirm   = 1'b1;
              w_state_nxt = S_PRESSED;
              w_cnt_nxt   = 4'd0;
            end else begin
              w_cnt_nxt = r_cnt + 4'd1;
            end
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
          end
        end
        S_PRESSED: begin
          if (w_none) begin
            if (c_DB == 4'd1) begin
              w_release   = 1'b1;
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = 4'd0;
            end else begin
              w_state_nxt = S_RELEASE;
              w_cnt_nxt   = 4'd1;
            end
          end
        end
        S_RELEASE: begin
          if (w_none) begin
            if (r_cnt + 4'd1 >= c_DB) begin
              w_release   = 1'b1;
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = 4'd0;
            end else begin
              w_cnt_nxt = r_cnt + 4'd1;
            end
          end else begin
            w_state_nxt = S_PRESSED;
            w_cnt_nxt   = 4'd0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_cand    <= 4'd0;
      Key_Code  <= 4'd0;
      Key_Valid <= 1'b0;
      Key_Held  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cand    <= w_cand_nxt;
      Key_Valid <= w_confirm;
      if (w_confirm) begin
        Key_Code <= w_cand_nxt;
        Key_Held <= 1'b1;
      end else if (w_release) begin
        Key_Held <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_module.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scan_module
// Description : Matrix-emulating bench with a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_module;

  localparam int SD = 4;
  localparam int DB = 2;
  localparam int FR = 4 * SD;

  logic       CLK;
  logic       RSTn;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] key_mask;
  int          cyc;
  int          n_cmp;
  int          n_bad;
  int          pulses;

  logic [15:0] fmask;
  int          streak;
  logic [3:0]  skey;
  int          gap;
  logic        m_held;
  logic [3:0]  m_code;
  logic        exp_valid;
  logic [3:0]  exp_col;
  logic [3:0]  one_hot;
  int          m_n;
  logic [3:0]  m_k;

  keypad_scan_module #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .Row_In   (row_in),
    .Col_Out  (col_out),
    .Key_Code (key_code),
    .Key_Valid(key_valid),
    .Key_Held (key_held)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Physical matrix: a pressed key pulls its row low while its column is driven
  always @* begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (key_mask[c*4+r] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model works on whole frames: classify the pressed-key set, then
  // apply streak counting for presses and gap counting for releases.
  always @(negedge CLK) begin
    exp_valid = 1'b0;
    if (!RSTn) begin
      fmask = '0; streak = 0; skey = '0; gap = 0; m_held = 1'b0; m_code = '0;
    end else begin
      if (cyc % FR == FR / 2) fmask = key_mask;
      if (cyc % FR == 0 && cyc != 0) begin
        m_n = $countones(fmask);
        m_k = '0;
        for (int i = 0; i < 16; i++) if (fmask[i]) m_k = 4'(i);
        if (!m_held) begin
          if (m_n == 1 && streak > 0 && m_k == skey) streak++;
          else if (m_n == 1 && streak == 0) begin streak = 1; skey = m_k; end
          else streak = 0;
          if (streak == DB) begin
            m_held = 1'b1; m_code = skey; exp_valid = 1'b1; streak = 0; gap = 0;
          end
        end else begin
          if (m_n == 0) gap++; else gap = 0;
          if (gap == DB) begin m_held = 1'b0; gap = 0; end
        end
      end
    end
    one_hot = 4'b0001 << ((cyc / SD) % 4);
    exp_col = ~one_hot;
    chk("col_out", col_out, exp_col);
    chk("key_valid", {3'b0, key_valid}, {3'b0, exp_valid});
    chk("key_code", key_code, m_code);
    chk("key_held", {3'b0, key_held}, {3'b0, m_held});
    if (key_valid) pulses++;
  end

  task automatic frames(input logic [15:0] m, input int n);
    key_mask = m;
    repeat (FR * n) @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_bad = 0; pulses = 0;
    key_mask = '0;
    RSTn = 1'b1;
    #1 RSTn = 1'b0;
    #1;
    chk("rst_col", col_out, 4'b1110);
    chk("rst_valid", {3'b0, key_valid}, 4'd0);
    repeat (3) @(posedge CLK);
    #1 RSTn = 1'b1;

    // idle scanning
    frames(16'h0000, 2);
    chk("t1_col_frame_start", col_out, 4'b1110);
    chk("t1_code", key_code, 4'd0);
    chk("t1_held", {3'b0, key_held}, 4'd0);
    chk("t1_pulses", 4'(pulses), 4'd0);

    // key 6 steady for 3 frames
    frames(16'h0040, 3);
    chk("t2_pulses", 4'(pulses), 4'd1);
    chk("t2_code", key_code, 4'd6);
    chk("t2_held", {3'b0, key_held}, 4'd1);

    // release
    frames(16'h0000, 2);
    chk("t3_held", {3'b0, key_held}, 4'd0);
    chk("t3_code", key_code, 4'd6);
    chk("t3_pulses", 4'(pulses), 4'd1);

    // bounce on key 9
    frames(16'h0200, 1);
    frames(16'h0000, 1);
    frames(16'h0200, 1);
    frames(16'h0000, 1);
    chk("t4_pulses", 4'(pulses), 4'd1);
    chk("t4_code", key_code, 4'd6);

    // keys 3 and 12 together, then 12 alone
    frames(16'h1008, 4);
    chk("t5_multi_pulses", 4'(pulses), 4'd1);
    frames(16'h0000, 1);
    frames(16'h1000, 2);
    frames(16'h1000, 1);
    chk("t5_pulses", 4'(pulses), 4'd2);
    chk("t5_code", key_code, 4'd12);
    frames(16'h0000, 2);
    chk("t5_held", {3'b0, key_held}, 4'd0);

    // reset in the middle of debouncing key 5
    frames(16'h0020, 1);
    repeat (5) @(posedge CLK);
    #1 RSTn = 1'b0;
    #1;
    chk("t6_rst_col", col_out, 4'b1110);
    chk("t6_rst_code", key_code, 4'd0);
    chk("t6_rst_valid", {3'b0, key_valid}, 4'd0);
    chk("t6_rst_held", {3'b0, key_held}, 4'd0);
    repeat (3) @(posedge CLK);
    #1 RSTn = 1'b1;
    frames(16'h0020, 1);
    chk("t6_one_frame_pulses", 4'(pulses), 4'd2);
    frames(16'h0020, 2);
    chk("t6_pulses", 4'(pulses), 4'd3);
    chk("t6_code", key_code, 4'd5);
    chk("t6_held", {3'b0, key_held}, 4'd1);
    frames(16'h0000, 2);
    chk("t6_release", {3'b0, key_held}, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_scan_module.md
Name: keypad_scan_module

Overview:
- Matrix-keypad reader for the quiz/timer front panel. It drives the input-side scan of a 4x4 key matrix, one active-low column at a time.
- It samples the active-low rows, debounces over whole scan frames and reports one confirmed key as a 4-bit code with a single-cycle valid strobe.
- It sits between the panel pins and the game controller. The controller consumes Key_Code and feeds Player_Number/timer values to the multiplexed digit display.

Parameters:
SCAN_DIV, 200, clocks per column step; legal range 4..65535.
DEBOUNCE_SCANS, 4, consecutive identical full frames needed to confirm a press or a release; legal range 1..15.

Ports:
CLK  input  1  system clock; all logic on posedge CLK.
RSTn  input  1  asynchronous active-low reset.
Row_In  input  4  matrix rows, active low, pulled up externally; asynchronous to CLK.
Col_Out  output  4  column drive, active low, exactly one bit low at all times.
Key_Code  output  4  last confirmed key index = column*4 + row (column 0 = Col_Out[0], row 0 = Row_In[0]).
Key_Valid  output  1  one-CLK pulse when a new press is confirmed.
Key_Held  output  1  high from confirmation until release is confirmed.

Behaviour:
- Reset (RSTn low, async), applied immediately:
  - Col_Out=4'b1110, Key_Code=0, Key_Valid=0, Key_Held=0.
  - FSM=IDLE; divider, column index, frame accumulators and debounce counter cleared.
  - Synchronizer flops set to 4'b1111.
  - Reset mid-frame or mid-debounce discards all partial state; no Key_Valid is emitted.
- Row_In passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- Divider counts 0..SCAN_DIV-1 and wraps. The cycle where divider==SCAN_DIV-1 is the step tick.
- On a step tick:
  - The synchronized rows are sampled for the current column.
  - Col_Out rotates 1110->1101->1011->0111->1110.
  - The column index wraps 3->0.
- Frame accumulation: over the four samples, record the number of low row bits (saturating at 2 = "multiple") and the index of the single low bit.
- Frame end = the step tick that samples column 3. The frame result is one of NONE, SINGLE(k) or MULTI, and is evaluated by the FSM on the next CLK. The accumulators clear for the next frame on that same tick.
- FSM, evaluated once per frame result:
  - IDLE:
    - SINGLE(k): candidate=k, cnt=1. If DEBOUNCE_SCANS==1, confirm immediately; otherwise go to DEBOUNCE.
    - NONE or MULTI: stay in IDLE.
  - DEBOUNCE:
    - SINGLE(candidate): cnt+1. When cnt reaches DEBOUNCE_SCANS, confirm.
    - NONE, MULTI or a different key: return to IDLE, cnt=0, no output change.
  - Confirm:
    - Key_Code<=candidate; Key_Valid=1 for exactly one CLK, in the cycle after the frame-end tick.
    - Key_Held<=1; go to PRESSED.
  - PRESSED:
    - NONE: go to RELEASE with cnt=1. If DEBOUNCE_SCANS==1, release immediately.
    - SINGLE (any key) or MULTI: stay in PRESSED. A second or different key never produces a new Key_Valid while held.
  - RELEASE:
    - NONE: cnt+1. At DEBOUNCE_SCANS, Key_Held<=0 and go to IDLE.
    - Any key seen: back to PRESSED, cnt=0.
- Key_Code holds its value until the next confirmation. It is not cleared on release.
- Latency: a clean press stable before frame start is confirmed DEBOUNCE_SCANS frames later, where one frame = 4*SCAN_DIV CLKs, plus 1 CLK.
- Counters never overflow: cnt saturates at DEBOUNCE_SCANS and the divider wraps.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2; frame=16 CLKs):
1. Reset release, no key -> Col_Out cycles 1110,1101,1011,0111 every 4 CLKs; Key_Valid never asserts; Key_Code=0, Key_Held=0.
2. Hold row 2 low only while Col_Out=1101 (key 6), steady for 3 frames -> exactly one Key_Valid pulse with Key_Code=4'd6 after the 2nd complete frame; Key_Held=1.
3. Release key 6 -> Key_Held falls after 2 consecutive empty frames; Key_Code stays 6; no Key_Valid.
4. Bounce: key 9 present 1 frame, absent 1 frame, present 1 frame, then absent -> no Key_Valid, Key_Code unchanged.
5. Keys 3 and 12 pressed together for 4 frames -> MULTI each frame, no Key_Valid; release both, then press key 12 alone for 2 frames -> Key_Valid with Key_Code=4'd12.
6. Assert RSTn low for 3 CLKs mid-DEBOUNCE of key 5 -> outputs return to reset values immediately; after release, key 5 held needs 2 fresh full frames before Key_Valid (Key_Code=4'd5).
